// File: rtl/data_mem_responder.sv
// Load/store responder for the core's data port: a word-organised RAM with
// byte/half/word sizing, sign/zero extension and programmable wait states.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        wr_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH];

  logic                  accept;
  logic                  cur_write;
  logic [31:0]           cur_addr;
  logic [1:0]            cur_size;
  logic                  cur_uns;
  logic [31:0]           cur_wdata;
  logic                  cur_err;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           mem_word;
  logic [31:0]           shifted;
  logic [7:0]            byte_val;
  logic [15:0]           half_val;
  logic [31:0]           load_data;
  logic [31:0]           lane_data;
  logic [31:0]           lane_mask;
  logic [31:0]           new_word;
  logic                  enter_resp;
  logic                  do_write;
  logic [31:0]           rsp_rdata_d;
  logic                  rsp_err_d;

  assign accept = (state_q == S_IDLE) && req_valid && req_ready;

  // With zero wait states RESP is entered on the accepting edge itself, so the
  // live request inputs must be used there instead of the latched copy.
  always_comb begin
    if (accept) begin
      cur_write = req_write;
      cur_addr  = req_addr;
      cur_size  = req_size;
      cur_uns   = req_unsigned;
      cur_wdata = req_wdata;
    end else begin
      cur_write = wr_q;
      cur_addr  = addr_q;
      cur_size  = size_q;
      cur_uns   = uns_q;
      cur_wdata = wdata_q;
    end
  end

  always_comb begin
    cur_err = 1'b0;
    if (cur_size == SZ_ILL) cur_err = 1'b1;
    if (cur_size == SZ_HALF && cur_addr[0]) cur_err = 1'b1;
    if (cur_size == SZ_WORD && cur_addr[1:0] != 2'b00) cur_err = 1'b1;
    if ((cur_addr[31:2] >> ADDR_WIDTH) != '0) cur_err = 1'b1;
  end

  assign idx      = cur_addr[ADDR_WIDTH+1:2];
  assign mem_word = mem[idx];
  assign shifted  = mem_word >> {cur_addr[1:0], 3'b000};
  assign byte_val = shifted[7:0];
  assign half_val = cur_addr[1] ? mem_word[31:16] : mem_word[15:0];

  always_comb begin
    load_data = mem_word;
    lane_data = cur_wdata;
    lane_mask = '1;
    unique case (cur_size)
      SZ_BYTE: begin
        load_data = cur_uns ? {24'b0, byte_val} : {{24{byte_val[7]}}, byte_val};
        lane_data = {4{cur_wdata[7:0]}};
        lane_mask = 32'h0000_00FF << {cur_addr[1:0], 3'b000};
      end
      SZ_HALF: begin
        load_data = cur_uns ? {16'b0, half_val} : {{16{half_val[15]}}, half_val};
        lane_data = {2{cur_wdata[15:0]}};
        lane_mask = cur_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      end
      default: begin
        load_data = mem_word;
        lane_data = cur_wdata;
        lane_mask = '1;
      end
    endcase
  end

  assign new_word = (mem_word & ~lane_mask) | (lane_data & lane_mask);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
  assign do_write   = enter_resp && cur_write && !cur_err && reset;

  always_comb begin
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    if (enter_resp) begin
      rsp_err_d   = cur_err;
      rsp_rdata_d = (cur_write || cur_err) ? '0 : load_data;
    end else if (state_d == S_IDLE) begin
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_ready <= (state_d == S_IDLE);
      rsp_valid <= (state_d == S_RESP);
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[idx] <= new_word;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: three instances with 1, 0 and 3
// wait states share one clock; each transaction pushes its expected response.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n        [3];
  logic        req_valid    [3];
  logic        req_ready    [3];
  logic        req_write    [3];
  logic [31:0] req_addr     [3];
  logic [1:0]  req_size     [3];
  logic        req_unsigned [3];
  logic [31:0] req_wdata    [3];
  logic        rsp_valid    [3];
  logic        rsp_ready    [3];
  logic [31:0] rsp_rdata    [3];
  logic        rsp_err      [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_responder #(
      .ADDR_WIDTH (10),
      .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) dut (
      .clk         (clk),
      .reset       (rst_n[g]),
      .req_valid   (req_valid[g]),
      .req_ready   (req_ready[g]),
      .req_write   (req_write[g]),
      .req_addr    (req_addr[g]),
      .req_size    (req_size[g]),
      .req_unsigned(req_unsigned[g]),
      .req_wdata   (req_wdata[g]),
      .rsp_valid   (rsp_valid[g]),
      .rsp_ready   (rsp_ready[g]),
      .rsp_rdata   (rsp_rdata[g]),
      .rsp_err     (rsp_err[g])
    );
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   ok;

  function automatic int wait_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int d, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready[d]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check({name, " ready"}, 32'(req_ready[d]), 32'd1);
  endtask

  task automatic txn(input int d, input string name, input logic wr,
                     input logic [31:0] addr, input logic [1:0] sz, input logic uns,
                     input logic [31:0] wd, input logic [31:0] exp_rd,
                     input logic exp_err, input int hold);
    int   lat;
    exp_t e;
    exp_t ex;
    ex.rdata = exp_rd;
    ex.err   = exp_err;
    sb.push_back(ex);
    wait_ready(d, name);
    req_write[d]    = wr;
    req_addr[d]     = addr;
    req_size[d]     = sz;
    req_unsigned[d] = uns;
    req_wdata[d]    = wd;
    req_valid[d]    = 1'b1;
    @(posedge clk);
    #1;
    req_valid[d]    = 1'b0;
    req_addr[d]     = $urandom;
    req_wdata[d]    = $urandom;
    req_write[d]    = 1'($urandom);
    req_size[d]     = 2'($urandom);
    req_unsigned[d] = 1'($urandom);
    lat = 1;
    while (!rsp_valid[d] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(wait_of(d) + 1));
    if (sb.size() == 0) begin
      check({name, " scoreboard"}, 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check({name, " rdata"}, rsp_rdata[d], e.rdata);
    check({name, " err"}, 32'(rsp_err[d]), 32'(e.err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({name, " hold valid"}, 32'(rsp_valid[d]), 32'd1);
      check({name, " hold rdata"}, rsp_rdata[d], e.rdata);
      check({name, " hold err"}, 32'(rsp_err[d]), 32'(e.err));
      check({name, " hold ready"}, 32'(req_ready[d]), 32'd0);
    end
    @(negedge clk);
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[d] = 1'b0;
    check({name, " valid drop"}, 32'(rsp_valid[d]), 32'd0);
    check({name, " ready back"}, 32'(req_ready[d]), 32'd1);
    check({name, " rdata clr"}, rsp_rdata[d], 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: n_tests %0d", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0;
      req_valid[d] = 1'b0;
      req_write[d] = 1'b0;
      req_addr[d] = '0;
      req_size[d] = '0;
      req_unsigned[d] = 1'b0;
      req_wdata[d] = '0;
      rsp_ready[d] = 1'b0;
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst req_ready", 32'(req_ready[d]), 32'd0);
      check("rst rsp_valid", 32'(rsp_valid[d]), 32'd0);
      check("rst rsp_rdata", rsp_rdata[d], 32'd0);
      check("rst rsp_err", 32'(rsp_err[d]), 32'd0);
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
    #1;
    check("rel ready low", 32'(req_ready[0]), 32'd0);
    @(posedge clk);
    #1;
    check("rel ready high", 32'(req_ready[0]), 32'd1);

    // one wait state: sizing, lanes, errors, backpressure
    txn(0, "sw10",   1'b1, 32'h10,   2'b10, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 0);
    txn(0, "lw10",   1'b0, 32'h10,   2'b10, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 0);
    txn(0, "lb13",   1'b0, 32'h13,   2'b00, 1'b0, 32'h0,        32'hFFFFFFDE, 1'b0, 0);
    txn(0, "lbu13",  1'b0, 32'h13,   2'b00, 1'b1, 32'h0,        32'h000000DE, 1'b0, 0);
    txn(0, "lh10",   1'b0, 32'h10,   2'b01, 1'b0, 32'h0,        32'hFFFFBEEF, 1'b0, 0);
    txn(0, "lhu12",  1'b0, 32'h12,   2'b01, 1'b1, 32'h0,        32'h0000DEAD, 1'b0, 0);
    txn(0, "sb11",   1'b1, 32'h11,   2'b00, 1'b0, 32'hFFFFFF55, 32'h0,        1'b0, 0);
    txn(0, "lw10b",  1'b0, 32'h10,   2'b10, 1'b0, 32'h0,        32'hDEAD55EF, 1'b0, 0);
    txn(0, "lh11",   1'b0, 32'h11,   2'b01, 1'b0, 32'h0,        32'h0,        1'b1, 0);
    txn(0, "lw12",   1'b0, 32'h12,   2'b10, 1'b0, 32'h0,        32'h0,        1'b1, 0);
    txn(0, "lsz3",   1'b0, 32'h10,   2'b11, 1'b0, 32'h0,        32'h0,        1'b1, 0);
    txn(0, "lw1000", 1'b0, 32'h1000, 2'b10, 1'b0, 32'h0,        32'h0,        1'b1, 0);
    txn(0, "sw12",   1'b1, 32'h12,   2'b10, 1'b0, 32'h11111111, 32'h0,        1'b1, 0);
    txn(0, "ssz3",   1'b1, 32'h10,   2'b11, 1'b0, 32'h22222222, 32'h0,        1'b1, 0);
    txn(0, "sw1010", 1'b1, 32'h1010, 2'b10, 1'b0, 32'h33333333, 32'h0,        1'b1, 0);
    txn(0, "lw10c",  1'b0, 32'h10,   2'b10, 1'b0, 32'h0,        32'hDEAD55EF, 1'b0, 5);
    txn(0, "sw14",   1'b1, 32'h14,   2'b10, 1'b0, 32'h11223344, 32'h0,        1'b0, 0);
    txn(0, "sh16",   1'b1, 32'h16,   2'b01, 1'b0, 32'h1234BEEF, 32'h0,        1'b0, 0);
    txn(0, "lw14u",  1'b0, 32'h14,   2'b10, 1'b1, 32'h0,        32'hBEEF3344, 1'b0, 0);
    txn(0, "lh16",   1'b0, 32'h16,   2'b01, 1'b0, 32'h0,        32'hFFFFBEEF, 1'b0, 0);
    txn(0, "lb14",   1'b0, 32'h14,   2'b00, 1'b0, 32'h0,        32'h00000044, 1'b0, 0);
    txn(0, "lb17",   1'b0, 32'h17,   2'b00, 1'b0, 32'h0,        32'hFFFFFFBE, 1'b0, 0);
    txn(0, "lbu15",  1'b0, 32'h15,   2'b00, 1'b1, 32'h0,        32'h00000033, 1'b0, 0);
    txn(0, "lhu14",  1'b0, 32'h14,   2'b01, 1'b1, 32'h0,        32'h00003344, 1'b0, 0);

    // zero wait states
    txn(1, "w0 sw10", 1'b1, 32'h10, 2'b10, 1'b0, 32'hA5A5A5A5, 32'h0,        1'b0, 0);
    txn(1, "w0 lw10", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0,        32'hA5A5A5A5, 1'b0, 2);
    txn(1, "w0 lb10", 1'b0, 32'h10, 2'b00, 1'b0, 32'h0,        32'hFFFFFFA5, 1'b0, 0);
    txn(1, "w0 lw2",  1'b0, 32'h2,  2'b10, 1'b0, 32'h0,        32'h0,        1'b1, 0);

    // three wait states, then reset while a store is waiting
    txn(2, "w3 sw20", 1'b1, 32'h20, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0,        1'b0, 0);
    txn(2, "w3 lw20", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0,        32'hCAFEF00D, 1'b0, 0);
    wait_ready(2, "w3 rst");
    req_write[2] = 1'b1;
    req_addr[2]  = 32'h20;
    req_size[2]  = 2'b10;
    req_wdata[2] = 32'h12345678;
    req_valid[2] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    @(posedge clk);
    #1;
    rst_n[2] = 1'b0;
    #1;
    check("mid rst req_ready", 32'(req_ready[2]), 32'd0);
    check("mid rst rsp_valid", 32'(rsp_valid[2]), 32'd0);
    check("mid rst rsp_rdata", rsp_rdata[2], 32'd0);
    check("mid rst rsp_err", 32'(rsp_err[2]), 32'd0);
    repeat (3) @(negedge clk);
    rst_n[2] = 1'b1;
    txn(2, "w3 lw20 after rst", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, 0);

    check("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder side of the core's load/store port: accepts one load or store request per transaction from the datapath's memory stage and returns read data and status.
- Word-organised RAM with RISC-V byte/half/word sizing and sign/zero extension.
- Programmable wait states let the multicycle and pipelined cores be exercised against non-zero memory latency.

Parameters:
- ADDR_WIDTH, 10, word-address bits; DEPTH = 2**ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 1, extra cycles between request acceptance and response (0 allowed).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extend (LBU/LHU); ignored for stores.
- req_wdata  in  32  store data, LSB-aligned (sb uses [7:0], sh uses [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range or illegal size.

Behaviour:
- FSM states: IDLE, WAIT, RESP. Reset (async, reset=0) forces IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. RAM contents are not reset.
- req_ready is registered: 1 only in IDLE. It rises on the first clk edge after reset deasserts.
- Accept on the edge where req_valid & req_ready. Latch write, addr, size, unsigned and wdata. Drop req_ready.
- After accepting: if WAIT_CYCLES=0, go to RESP. Otherwise go to WAIT with counter=WAIT_CYCLES-1, decrement each edge, and go to RESP when the counter is 0.
- rsp_valid rises exactly WAIT_CYCLES+1 edges after the accepting edge.
- On the edge entering RESP:
  - Store: performed (lane-masked RAM write).
  - Load: rsp_rdata registered.
  - rsp_err registered.
- RESP holds rsp_valid, rsp_rdata and rsp_err stable until rsp_ready=1. On that edge go to IDLE, clear rsp_valid, rsp_rdata and rsp_err, and set req_ready.
- Back-to-back throughput is one transaction per WAIT_CYCLES+2 cycles minimum; there is one IDLE bubble.
- Error conditions:
  - size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:2] >= DEPTH.
- On error: no RAM write, rsp_rdata=0, rsp_err=1, normal handshake.
- Lane select: byte lane = addr[1:0]; half lane = addr[1].
  - Loads are sign-extended from bit 7 or bit 15 unless req_unsigned=1.
  - Word loads ignore req_unsigned.
- Stores update only the addressed byte/half lanes; other lanes are preserved.
- Inputs are ignored outside the accepting edge. rsp_ready is ignored outside RESP.
- Reset asserted in WAIT: store is discarded (not written). Reset asserted in RESP: response is lost; a store already entering RESP stays committed.

Test Plan:
- WAIT_CYCLES=1: sw 0xDEADBEEF to addr 0x10, then lw 0x10 → store response rsp_err=0, rsp_rdata=0; load rsp_rdata=0xDEADBEEF; rsp_valid rises 2 edges after each accept.
- Sizing: after the word above, lb 0x13 → 0xFFFFFFDE; lbu 0x13 → 0x000000DE; lh 0x10 → 0xFFFFBEEF; lhu 0x12 → 0x0000DEAD; sb 0x55 to 0x11 then lw 0x10 → 0xDEAD55EF.
- Errors: lh 0x11, lw 0x12, size=11, lw 0x1000 (ADDR_WIDTH=10) → each returns rsp_err=1, rsp_rdata=0; a following lw 0x10 → 0xDEAD55EF (memory unchanged).
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_rdata and rsp_err are stable and req_ready=0 throughout; when rsp_ready=1, rsp_valid drops on the next edge and req_ready=1.
- WAIT_CYCLES=0 and 3 builds: lw latency is exactly 1 and 4 edges from accept to rsp_valid.
- Reset mid-WAIT (WAIT_CYCLES=3): sw 0x12345678 to 0x20 then reset=0 one cycle later → outputs are 0 immediately (async); after release, lw 0x20 returns the prior contents, not 0x12345678.
